// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one synchronous single-port memory between the instruction-fetch
// port (if_*) and the data port (d_*). Every access takes four cycles:
// IDLE (arbitrate) -> ISSUE (mem_en) -> WAIT (capture mem_rdata) -> RESP (ack).
// Data has priority, except that a fetch is forced through after STARVE_MAX
// consecutive data grants made while a fetch was waiting.
//
// Ports:
//   clk, reset              clock (rising edge), async active-low reset
//   if_req/if_addr          fetch request, held until if_ack
//   if_flush                taken branch; kills the outstanding fetch
//   if_ack/if_rdata         fetch completion pulse and instruction word
//   d_req/d_we/d_addr/d_wdata  data request, held until d_ack
//   d_ack/d_rdata           data completion pulse and load data
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata  memory side
//   stall_f                 if_req & ~if_ack, freezes the Fetch stage
module mem_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        if_flush,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        stall_f
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t      state_q, state_d;
    logic        own_f_q, own_f_d;     // 1 = fetch owns the access
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        kill_q, kill_d;       // fetch flushed during ISSUE
    logic [2:0]  starve_q, starve_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;

    logic starve_hit;
    logic grant_f;
    logic grant_d;

    assign starve_hit = ({29'd0, starve_q} == STARVE_MAX);
    // A flush in IDLE blocks the fetch grant; data may still go.
    assign grant_f = if_req && !if_flush && (!d_req || starve_hit);
    assign grant_d = d_req && !grant_f;

    always_comb begin
        state_d    = state_q;
        own_f_d    = own_f_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        kill_d     = kill_q;
        starve_d   = starve_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        case (state_q)
            IDLE: begin
                if (grant_d) begin
                    state_d = ISSUE;
                    own_f_d = 1'b0;
                    we_d    = d_we;
                    addr_d  = d_addr;
                    wdata_d = d_wdata;
                    kill_d  = 1'b0;
                    if (if_req && starve_q != 3'b111)
                        starve_d = starve_q + 3'd1;
                end else if (grant_f) begin
                    state_d  = ISSUE;
                    own_f_d  = 1'b1;
                    we_d     = 1'b0;
                    addr_d   = if_addr;
                    kill_d   = 1'b0;
                    starve_d = 3'd0;
                end
            end
            ISSUE: begin
                state_d = WAIT;
                if (own_f_q && if_flush)
                    kill_d = 1'b1;
            end
            WAIT: begin
                // A killed fetch lets the memory access finish but drops
                // the response and leaves if_rdata alone.
                if (own_f_q && (kill_q || if_flush)) begin
                    state_d = IDLE;
                end else begin
                    state_d = RESP;
                    if (own_f_q)
                        if_rdata_d = mem_rdata;
                    else if (!we_q)
                        d_rdata_d = mem_rdata;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            own_f_q    <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            kill_q     <= 1'b0;
            starve_q   <= 3'd0;
            if_rdata_q <= 32'h0;
            d_rdata_q  <= 32'h0;
        end else begin
            state_q    <= state_d;
            own_f_q    <= own_f_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            kill_q     <= kill_d;
            starve_q   <= starve_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    assign mem_en    = (state_q == ISSUE);
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign if_ack    = (state_q == RESP) && own_f_q;
    assign d_ack     = (state_q == RESP) && !own_f_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign stall_f   = if_req && !if_ack;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter. Inputs change and outputs are checked on
// the falling clock edge; the memory model is a synchronous RAM stand-in.
module tb_mem_arbiter;

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_flush;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        stall_f;

    int checks = 0;
    int errors = 0;

    logic [31:0] st_addr;
    logic [31:0] st_data;

    mem_arbiter #(.STARVE_MAX(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_flush  (if_flush),
        .if_ack    (if_ack),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_ack     (d_ack),
        .d_rdata   (d_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .stall_f   (stall_f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] a);
        case (a)
            32'h0000_0010: rom = 32'h0050_0093;
            32'h0000_0020: rom = 32'h1234_5678;
            32'h0000_0030: rom = 32'hCAFE_F00D;
            32'h0000_0100: rom = 32'h0000_ABCD;
            32'h0000_0104: rom = 32'h55AA_55AA;
            default:       rom = a ^ 32'hA5A5_0000;
        endcase
    endfunction

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                st_addr <= mem_addr;
                st_data <= mem_wdata;
            end else begin
                mem_rdata <= rom(mem_addr);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        reset    = 1'b0;
        if_req   = 1'b0;
        if_addr  = 32'h0;
        if_flush = 1'b0;
        d_req    = 1'b0;
        d_we     = 1'b0;
        d_addr   = 32'h0;
        d_wdata  = 32'h0;
        mem_rdata = 32'h0;
        st_addr  = 32'h0;
        st_data  = 32'h0;

        // ---- reset state ----
        step(); step();
        chk("rst_if_ack",   {31'd0, if_ack}, 32'd0);
        chk("rst_d_ack",    {31'd0, d_ack},  32'd0);
        chk("rst_mem_en",   {31'd0, mem_en}, 32'd0);
        chk("rst_mem_we",   {31'd0, mem_we}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_if_rdata", if_rdata, 32'h0);
        chk("rst_d_rdata",  d_rdata,  32'h0);
        if_req = 1'b1; #1;
        chk("rst_stall_f_follows", {31'd0, stall_f}, 32'd1);
        if_req = 1'b0; #1;
        chk("rst_stall_f_low", {31'd0, stall_f}, 32'd0);
        step();
        reset = 1'b1;
        step();

        // ---- fetch alone ----
        if_req = 1'b1; if_addr = 32'h10; #1;
        chk("f_c0_stall", {31'd0, stall_f}, 32'd1);
        chk("f_c0_mem_en", {31'd0, mem_en}, 32'd0);
        step();
        chk("f_c1_mem_en", {31'd0, mem_en}, 32'd1);
        chk("f_c1_mem_we", {31'd0, mem_we}, 32'd0);
        chk("f_c1_addr", mem_addr, 32'h10);
        chk("f_c1_stall", {31'd0, stall_f}, 32'd1);
        step();
        chk("f_c2_mem_en", {31'd0, mem_en}, 32'd0);
        chk("f_c2_if_ack", {31'd0, if_ack}, 32'd0);
        chk("f_c2_stall", {31'd0, stall_f}, 32'd1);
        step();
        chk("f_c3_if_ack", {31'd0, if_ack}, 32'd1);
        chk("f_c3_d_ack", {31'd0, d_ack}, 32'd0);
        chk("f_c3_if_rdata", if_rdata, 32'h0050_0093);
        chk("f_c3_stall", {31'd0, stall_f}, 32'd0);
        if_req = 1'b0;
        step();
        chk("f_c4_if_ack", {31'd0, if_ack}, 32'd0);
        chk("f_c4_if_rdata_hold", if_rdata, 32'h0050_0093);

        // ---- simultaneous requests: data first ----
        if_req = 1'b1; if_addr = 32'h10;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
        step();
        chk("s_t1_addr", mem_addr, 32'h100);
        chk("s_t1_mem_en", {31'd0, mem_en}, 32'd1);
        step(); step();
        chk("s_t3_d_ack", {31'd0, d_ack}, 32'd1);
        chk("s_t3_if_ack", {31'd0, if_ack}, 32'd0);
        chk("s_t3_d_rdata", d_rdata, 32'h0000_ABCD);
        d_req = 1'b0;
        step();
        chk("s_t4_mem_en", {31'd0, mem_en}, 32'd0);
        chk("s_t4_d_ack", {31'd0, d_ack}, 32'd0);
        step();
        chk("s_t5_mem_en", {31'd0, mem_en}, 32'd1);
        chk("s_t5_addr", mem_addr, 32'h10);
        step(); step();
        chk("s_t7_if_ack", {31'd0, if_ack}, 32'd1);
        chk("s_t7_d_ack", {31'd0, d_ack}, 32'd0);
        if_req = 1'b0;
        step();

        // ---- starvation: D,D,D,D,I,D ----
        if_req = 1'b1; if_addr = 32'h10;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
        for (int t = 0; t < 6; t++) begin
            step();
            chk($sformatf("starve_%0d_addr", t), mem_addr, (t == 4) ? 32'h10 : 32'h100);
            step(); step();
            chk($sformatf("starve_%0d_d_ack", t),  {31'd0, d_ack},  (t == 4) ? 32'd0 : 32'd1);
            chk($sformatf("starve_%0d_if_ack", t), {31'd0, if_ack}, (t == 4) ? 32'd1 : 32'd0);
            step();
        end
        if_req = 1'b0; d_req = 1'b0;
        step();

        // ---- store ----
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'hDEAD_BEEF;
        step();
        chk("st_mem_en", {31'd0, mem_en}, 32'd1);
        chk("st_mem_we", {31'd0, mem_we}, 32'd1);
        chk("st_addr", mem_addr, 32'h200);
        chk("st_wdata", mem_wdata, 32'hDEAD_BEEF);
        step(); step();
        chk("st_d_ack", {31'd0, d_ack}, 32'd1);
        chk("st_d_rdata_hold", d_rdata, 32'h0000_ABCD);
        chk("st_mem_seen", st_data, 32'hDEAD_BEEF);
        d_req = 1'b0; d_we = 1'b0;
        step();
        chk("st_d_ack_pulse", {31'd0, d_ack}, 32'd0);

        // ---- flush: blocked in IDLE, then killed in WAIT ----
        if_req = 1'b1; if_addr = 32'h20; if_flush = 1'b1;
        step();
        chk("fl_idle_block", {31'd0, mem_en}, 32'd0);
        if_flush = 1'b0;
        step();
        chk("fl_issue_addr", mem_addr, 32'h20);
        step();
        if_flush = 1'b1; if_addr = 32'h30;
        step();
        chk("fl_no_ack", {31'd0, if_ack}, 32'd0);
        chk("fl_idle_mem_en", {31'd0, mem_en}, 32'd0);
        chk("fl_rdata_hold", if_rdata, 32'h0050_0093);
        if_flush = 1'b0;
        step();
        chk("fl_new_mem_en", {31'd0, mem_en}, 32'd1);
        chk("fl_new_addr", mem_addr, 32'h30);
        step(); step();
        chk("fl_new_ack", {31'd0, if_ack}, 32'd1);
        chk("fl_new_rdata", if_rdata, 32'hCAFE_F00D);
        if_req = 1'b0;
        step();

        // ---- reset in WAIT of a load ----
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h104;
        step();
        chk("rw_issue", {31'd0, mem_en}, 32'd1);
        step();
        reset = 1'b0; #1;
        chk("rw_mem_en", {31'd0, mem_en}, 32'd0);
        chk("rw_mem_addr", mem_addr, 32'h0);
        chk("rw_d_rdata", d_rdata, 32'h0);
        chk("rw_if_rdata", if_rdata, 32'h0);
        d_req = 1'b0;
        step(); step();
        chk("rw_no_d_ack", {31'd0, d_ack}, 32'd0);
        reset = 1'b1;
        step();
        d_req = 1'b1;
        step();
        chk("rw_resume_addr", mem_addr, 32'h104);
        step(); step();
        chk("rw_resume_ack", {31'd0, d_ack}, 32'd1);
        chk("rw_resume_rdata", d_rdata, 32'h55AA_55AA);
        d_req = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Acks must never overlap.
    always @(negedge clk) begin
        if (if_ack && d_ack) begin
            errors++;
            $error("FAIL ack_exclusive: observed both acks expected at most one");
        end
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The parameter list SHALL be: STARVE_MAX, default 4, the number of consecutive data grants allowed while a fetch is waiting.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-003 The ports SHALL be, clock and reset first, one per line:
 clk  in  1  system clock, rising edge
 reset  in  1  asynchronous active-low reset
 if_req  in  1  fetch request; held with if_addr until if_ack
 if_addr  in  32  fetch word address
 if_flush  in  1  taken branch in Execute; kills the outstanding fetch
 if_ack  out  1  one-cycle fetch completion pulse
 if_rdata  out  32  fetched instruction, valid while if_ack=1
 d_req  in  1  data request; held with d_we, d_addr, d_wdata until d_ack
 d_we  in  1  1 = store, 0 = load
 d_addr  in  32  data address
 d_wdata  in  32  store data
 d_ack  out  1  one-cycle data completion pulse
 d_rdata  out  32  load data, valid while d_ack=1 and the access was a load
 mem_en  out  1  memory access strobe
 mem_we  out  1  memory write enable
 mem_addr  out  32  memory address
 mem_wdata  out  32  memory write data
 mem_rdata  in  32  synchronous memory read data, valid the cycle after mem_en
 stall_f  out  1  equals if_req AND NOT if_ack; freezes the Fetch stage

Function
REQ-004 The FSM SHALL have the states IDLE, ISSUE, WAIT and RESP, with the transitions IDLE -> ISSUE on a grant, ISSUE -> WAIT, WAIT -> RESP, and RESP -> IDLE.
REQ-005 In IDLE, the arbiter SHALL grant data when d_req=1 and fetch when if_req=1 and d_req=0; when both are high, data wins unless the starvation counter equals STARVE_MAX.
REQ-006 On a grant, the owner, we, addr and wdata SHALL be latched into registers that drive mem_we, mem_addr and mem_wdata; a fetch grant forces mem_we=0.
REQ-007 mem_en SHALL be 1 only in ISSUE.
REQ-008 The arbiter SHALL register mem_rdata at the end of WAIT into the owner's rdata register; on a store, d_rdata keeps its previous value.
REQ-009 In RESP, the owner's ack SHALL be 1 for exactly one cycle; the other ack stays 0.
REQ-010 Latency: a request sampled in IDLE in cycle T SHALL be acked in cycle T+3, and the next grant can occur no earlier than T+4.
REQ-011 A request still high in the IDLE cycle after its ack SHALL be treated as a new request.
REQ-012 The starvation counter is 3 bits and saturating. It SHALL increment on each data grant made while if_req=1, and clear on every fetch grant.
REQ-013 When if_flush=1 in IDLE, the arbiter SHALL not grant a fetch that cycle; a pending data request may still be granted.
REQ-014 When if_flush=1 while a fetch owns ISSUE or WAIT, the memory access SHALL complete, but RESP is skipped: WAIT -> IDLE, no if_ack, and if_rdata is unchanged.
REQ-015 A flush during a data access SHALL have no effect on that access.
REQ-016 An ack SHALL never be asserted for a requester that was not granted.
REQ-017 Acks are mutually exclusive; if_ack and d_ack SHALL never both be 1.

Reset
REQ-018 When reset=0, the block SHALL asynchronously enter IDLE and clear the starvation counter, every output register, if_ack, d_ack and mem_en to 0, and set if_rdata and d_rdata to 32'h0.
REQ-019 Reset asserted mid-operation SHALL abort the access with no ack; after release, arbitration restarts from IDLE.
REQ-020 stall_f SHALL follow if_req during reset, because it is combinational.

Verification
REQ-021 Fetch alone: if_req=1, if_addr=32'h0000_0010, mem returns 32'h0050_0093 -> mem_en in cycle 1, if_ack and if_rdata=32'h0050_0093 in cycle 3, and stall_f=1 in cycles 0-2.
REQ-022 Simultaneous requests: if_req=d_req=1 and d_addr=32'h100 -> d_ack first, then the fetch is granted at T+4 with if_ack at T+7.
REQ-023 Starvation: if_req and d_req held high for 6 transactions -> the grant order is D,D,D,D,I,D and the counter clears after the I.
REQ-024 Store: d_we=1, d_addr=32'h200, d_wdata=32'hDEAD_BEEF -> mem_we=1 with that address and data in ISSUE, d_ack pulses, and d_rdata is unchanged.
REQ-025 Flush: if_flush pulses in WAIT of a fetch -> no if_ack, and a fresh fetch is granted in the next IDLE.
REQ-026 Reset in WAIT -> no ack, all outputs are 0 immediately, and normal operation resumes after release.
